// File: rtl/hqm_rcfwl_gclk_pccdu_dop_ctl.sv
// DOP clock-enable controller: generates the periodic divider-sync pulse and
// aligns DOP clock-enable rise/fall to that pulse, with a scan bypass path.
module hqm_rcfwl_gclk_pccdu_dop_ctl #(
  parameter int SYNC_PERIOD = 12
) (
  input  logic       fdop_preclk_grid,
  input  logic       fdop_reset_b,
  input  logic       gclk_sync_en,
  input  logic       gclk_clken_req,
  input  logic       gclk_scan_byp,
  output logic       fdop_preclk_div_sync,
  output logic       fscan_dop_clken,
  output logic       gclk_clken_ack,
  output logic [1:0] gclk_state
);

  localparam int CNT_W = $clog2(SYNC_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_PERIOD - 1);

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    WAIT_ON  = 2'd1,
    ON       = 2'd2,
    WAIT_OFF = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sync;
  logic             clken;

  // Phase counter; restarts from zero whenever sync generation is disabled,
  // so the first pulse always follows the first enabled edge.
  always_ff @(posedge fdop_preclk_grid or negedge fdop_reset_b) begin
    if (!fdop_reset_b) begin
      cnt  <= '0;
      sync <= 1'b0;
    end else if (!gclk_sync_en) begin
      cnt  <= '0;
      sync <= 1'b0;
    end else begin
      sync <= (cnt == '0);
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge fdop_preclk_grid or negedge fdop_reset_b) begin
    if (!fdop_reset_b) begin
      state <= OFF;
      clken <= 1'b0;
    end else begin
      state <= state_nxt;
      clken <= (state_nxt == ON) || (state_nxt == WAIT_OFF);
    end
  end

  // Transitions key off the registered sync pulse, so clken moves the cycle
  // after the pulse the DOP divider sees.
  always_comb begin
    state_nxt = state;
    if (gclk_scan_byp) begin
      state_nxt = gclk_clken_req ? ON : OFF;
    end else begin
      case (state)
        OFF: begin
          if (gclk_clken_req && gclk_sync_en) state_nxt = WAIT_ON;
        end
        WAIT_ON: begin
          if (!gclk_clken_req || !gclk_sync_en) state_nxt = OFF;
          else if (sync)                        state_nxt = ON;
        end
        ON: begin
          if (!gclk_clken_req) state_nxt = WAIT_OFF;
        end
        WAIT_OFF: begin
          if (gclk_clken_req)     state_nxt = ON;
          else if (!gclk_sync_en) state_nxt = OFF;
          else if (sync)          state_nxt = OFF;
        end
        default: state_nxt = OFF;
      endcase
    end
  end

  assign fdop_preclk_div_sync = sync;
  assign fscan_dop_clken      = clken;
  assign gclk_clken_ack       = clken;
  assign gclk_state           = state;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_pccdu_dop_ctl.sv
// Directed bench for the DOP clock-enable controller at SYNC_PERIOD=4.
module tb_hqm_rcfwl_gclk_pccdu_dop_ctl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       sync_en, req, byp;
  logic       div_sync, clken, ack;
  logic [1:0] st;

  int checks = 0;
  int failures = 0;

  hqm_rcfwl_gclk_pccdu_dop_ctl #(.SYNC_PERIOD(4)) dut (
    .fdop_preclk_grid     (clk),
    .fdop_reset_b         (rst_b),
    .gclk_sync_en         (sync_en),
    .gclk_clken_req       (req),
    .gclk_scan_byp        (byp),
    .fdop_preclk_div_sync (div_sync),
    .fscan_dop_clken      (clken),
    .gclk_clken_ack       (ack),
    .gclk_state           (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, rq, by;
    logic       e_sync, e_clken;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, rq, by, es, ec, input logic [1:0] est);
    vec_t v;
    v.en = en; v.rq = rq; v.by = by; v.e_sync = es; v.e_clken = ec; v.e_st = est;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [1:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic es, ec, input logic [1:0] est);
    chk({tag, "_sync"}, idx, {1'b0, div_sync}, {1'b0, es});
    chk({tag, "_clken"}, idx, {1'b0, clken}, {1'b0, ec});
    chk({tag, "_ack"}, idx, {1'b0, ack}, {1'b0, ec});
    chk({tag, "_state"}, idx, st, est);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row i is driven in cycle i; expectations are for cycle i+1.
    add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,1,0, 0,0,1); add(1,1,0, 0,0,1);
    add(1,1,0, 1,0,1); add(1,1,0, 0,1,2); add(1,1,0, 0,1,2); add(1,0,0, 0,1,3);
    add(1,0,0, 1,1,3); add(1,0,0, 0,0,0);
    // req drops on the edge that sees the WAIT_ON sync pulse
    add(1,1,0, 0,0,1); add(1,1,0, 0,0,1); add(1,1,0, 1,0,1); add(1,0,0, 0,0,0);
    add(1,0,0, 0,0,0);
    // req re-raised in WAIT_OFF keeps clken high
    add(1,1,0, 0,0,1); add(1,1,0, 1,0,1); add(1,1,0, 0,1,2); add(1,0,0, 0,1,3);
    add(1,1,0, 0,1,2); add(1,1,0, 1,1,2); add(1,1,0, 0,1,2);
    // sync_en drop: ON holds, pulses stop, phase restarts on re-enable
    add(0,1,0, 0,1,2); add(0,1,0, 0,1,2); add(1,1,0, 1,1,2); add(1,1,0, 0,1,2);
    add(1,0,0, 0,1,3); add(0,0,0, 0,0,0);
    // scan bypass without sync
    add(0,1,1, 0,1,2); add(0,0,1, 0,0,0); add(0,1,0, 0,0,0);

    rst_b = 1'b0; sync_en = 1'b0; req = 1'b0; byp = 1'b0;
    #1;
    chk_all("reset_async", 0, 0, 0, 2'd0);
    step(); step();
    chk_all("reset_held", 0, 0, 0, 2'd0);
    rst_b = 1'b1;
    step();
    chk_all("post_reset", 0, 0, 0, 2'd0);

    foreach (vecs[i]) begin
      sync_en = vecs[i].en; req = vecs[i].rq; byp = vecs[i].by;
      step();
      chk_all("vec", i, vecs[i].e_sync, vecs[i].e_clken, vecs[i].e_st);
    end

    // Async reset mid-ON, observed without any clock edge
    sync_en = 1'b1; req = 1'b1; byp = 1'b1;
    step();
    chk_all("pre_rst_on", 0, 1, 1, 2'd2);
    #2 rst_b = 1'b0;
    #1;
    chk_all("mid_on_rst", 0, 0, 0, 2'd0);
    sync_en = 1'b0; req = 1'b0; byp = 1'b0;
    step();
    rst_b = 1'b1;
    step();
    chk_all("rst_release", 0, 0, 0, 2'd0);
    // Release sequence: enable in cycle 0, pulses at cycles 1, 5, 9
    sync_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("release_sync", k, {1'b0, div_sync}, {1'b0, (k % 4) == 1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hqm_rcfwl_gclk_pccdu_dop_ctl.md
HQM_RCFWL_GCLK_PCCDU_DOP_CTL -- requirements
Module: hqm_rcfwl_gclk_pccdu_dop_ctl

Interface
REQ-001 SHALL have parameter SYNC_PERIOD, default 12, divider-sync period in grid-clock cycles; legal range 2..255 (covers LCM of DOP divisors 2/3/4/12).
REQ-002 SHALL have localparam CNT_W = $clog2(SYNC_PERIOD), the phase counter width.
REQ-003 SHALL have port fdop_preclk_grid  in  1  grid pre-clock; the only clock, and all flops are posedge.
REQ-004 SHALL have port fdop_reset_b  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port gclk_sync_en  in  1  level; enables periodic divider-sync generation.
REQ-006 SHALL have port gclk_clken_req  in  1  level; request for a running DOP clock.
REQ-007 SHALL have port gclk_scan_byp  in  1  level; scan bypass, enables the clock without sync alignment.
REQ-008 SHALL have port fdop_preclk_div_sync  out  1  single-cycle divider-sync pulse to the DOP.
REQ-009 SHALL have port fscan_dop_clken  out  1  DOP clock enable.
REQ-010 SHALL have port gclk_clken_ack  out  1  equals fscan_dop_clken, for the requester.
REQ-011 SHALL have port gclk_state  out  2  FSM encoding: OFF=0, WAIT_ON=1, ON=2, WAIT_OFF=3.

Function
REQ-012 All outputs SHALL be registered, with no combinational input-to-output paths.
REQ-013 Phase counter cnt: while gclk_sync_en=0, cnt<=0 and sync pulse<=0.
REQ-014 Phase counter cnt: while gclk_sync_en=1, sync<=(cnt==0) and cnt<=(cnt==SYNC_PERIOD-1)?0:cnt+1.
REQ-015 First fdop_preclk_div_sync SHALL be high the cycle after gclk_sync_en is first sampled 1, then exactly every SYNC_PERIOD cycles, each pulse 1 cycle wide.
REQ-016 Deasserting gclk_sync_en SHALL stop pulses from the next edge; reasserting it SHALL restart the phase per REQ-015.
REQ-017 FSM OFF: clken=0; go to WAIT_ON when gclk_clken_req=1 and gclk_sync_en=1.
REQ-018 FSM WAIT_ON: clken=0; go to ON on the edge where fdop_preclk_div_sync=1, so clken rises the cycle after the sync pulse.
REQ-019 FSM WAIT_ON: go to OFF if gclk_clken_req=0 or gclk_sync_en=0; this exit has priority over the sync pulse.
REQ-020 FSM ON: clken=1; go to WAIT_OFF when gclk_clken_req=0.
REQ-021 FSM ON: SHALL stay in ON if gclk_sync_en drops.
REQ-022 FSM WAIT_OFF: clken=1; go to OFF on the edge where fdop_preclk_div_sync=1, so clken falls the cycle after the pulse.
REQ-023 FSM WAIT_OFF: go to ON if gclk_clken_req reasserts; request priority is above the sync pulse.
REQ-024 FSM WAIT_OFF: go to OFF immediately if gclk_sync_en=0.
REQ-025 gclk_scan_byp=1 SHALL override all FSM transitions: next state ON if gclk_clken_req=1, else OFF, with 1-cycle latency and no sync wait.
REQ-026 gclk_scan_byp SHALL NOT affect the counter or pulses.
REQ-027 Exiting bypass SHALL resume normal transitions from the current state.
REQ-028 fscan_dop_clken and gclk_clken_ack SHALL be 1 exactly in states ON and WAIT_OFF, registered together with the state.

Reset
REQ-029 fdop_reset_b=0 SHALL asynchronously force state=OFF, cnt=0, fdop_preclk_div_sync=0, fscan_dop_clken=0, gclk_clken_ack=0, gclk_state=0.
REQ-030 Reset deassertion SHALL be synchronous to the grid clock (externally synchronized); the first pulse comes no earlier than the 2nd edge after release with gclk_sync_en=1.
REQ-031 Reset mid-operation (ON, WAIT_*) SHALL drop clken in the same cycle, with no partial pulse.

Verification (SYNC_PERIOD=4)
REQ-032 Enable sync: raise gclk_sync_en at edge 0 -> pulse at cycles 1, 5, 9; never 2 cycles wide.
REQ-033 Enable clock: req=1 at cycle 2 -> state WAIT_ON at cycle 3, sync at 5, clken=ack=1 from cycle 6.
REQ-034 Disable clock: req=0 at cycle 7 -> WAIT_OFF at 8, clken held through sync at 9, clken=0 at 10.
REQ-035 Boundary cases:
- req=0 on the same edge as the WAIT_ON sync pulse -> OFF, clken never rises.
- req re-raised in WAIT_OFF -> ON, clken stays 1 continuously.
REQ-036 Scan bypass: gclk_scan_byp=1, req=1 with gclk_sync_en=0 -> clken=1 the next cycle; req=0 -> clken=0 the next cycle; pulses absent.
REQ-037 Async reset: reset asserted mid-ON -> all outputs 0 without a clock edge; the release sequence matches REQ-032.
